uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance between N byte-stream requesters using round-robin arbitration with packet locking.
- Each requester offers bytes through a valid/ready handshake; a packet is terminated by a last flag.
- The block captures one byte at a time, drives uart_tx's data and start inputs, and tracks completion through uart_tx's idle output.
- It sits between the system-side message sources and the uart_tx peripheral.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types, widths and timing helpers for the UART transmit path.
package uart_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_e;

  // Clocks per serial bit for a given system clock and baud rate.
  function automatic int unsigned clks_per_bit(input int unsigned fclk, input int unsigned baud);
    return fclk / baud;
  endfunction

  // Clocks per whole frame: start bit, width data bits, one stop bit.
  function automatic int unsigned clks_per_frame(input int unsigned fclk, input int unsigned baud,
                                                 input int unsigned width);
    return (fclk / baud) * (width + 2);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Cyclic priority encoder: first set request at or after ptr, wrapping at N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          found
);

  logic [PW-1:0] idx;

  // Walk the requesters starting at ptr and keep only the first hit.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = PW'((32'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one uart_tx among N byte streams.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned LOCK_TIMEOUT = 1023
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [N-1:0]       req_valid_i,
  input  logic [N*WIDTH-1:0] req_data_i,
  input  logic [N-1:0]       req_last_i,
  output logic [N-1:0]       req_ready_o,
  output logic [N-1:0]       grant_o,
  output logic [WIDTH-1:0]   data_o,
  output logic               tx_start_o,
  input  logic               idle_i,
  output logic               busy_o,
  output logic               timeout_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [PW-1:0]    ptr_q, owner_q, owner_inc, win_idx;
  logic             lock_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] data_q, win_data;
  logic             tx_start_q, busy_q, timeout_q;
  logic [N-1:0]     owner_oh, cand, pick_gnt;
  logic             pick_found, in_arb, accept, stall, tmo_hit, win_last;

  // While locked, only the owner may compete.
  assign owner_oh  = N'(1) << owner_q;
  assign cand      = lock_q ? (req_valid_i & owner_oh) : req_valid_i;
  assign owner_inc = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req   (cand),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  // One-hot winner to lane index.
  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (pick_gnt[k]) win_idx = PW'(k);
    end
  end

  assign win_data = req_data_i[32'(win_idx) * WIDTH +: WIDTH];
  assign win_last = req_last_i[win_idx];
  assign in_arb   = (state_q == ARB);
  assign accept   = in_arb && idle_i && pick_found;
  assign stall    = in_arb && lock_q && !req_valid_i[owner_q];
  assign tmo_hit  = stall && (cnt_q == CW'(LOCK_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ARB;
    else          state_q <= state_d;
  end

  // Next state plus the combinational handshake and grant outputs.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    grant_o     = owner_oh;
    case (state_q)
      ARB: begin
        grant_o = pick_gnt;
        if (accept) begin
          req_ready_o = pick_gnt;
          state_d     = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!idle_i) state_d = WAIT_DONE;
      WAIT_DONE: if (idle_i) state_d = ARB;
      default:   state_d = ARB;
    endcase
  end

  // Byte capture, lock/owner/pointer bookkeeping and the stall timeout.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_q     <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tx_start_q <= accept;
      busy_q     <= (state_d != ARB);
      timeout_q  <= tmo_hit;
      if (accept) begin
        data_q  <= win_data;
        owner_q <= win_idx;
        lock_q  <= ~win_last;
        cnt_q   <= '0;
      end else if (tmo_hit) begin
        lock_q <= 1'b0;
        ptr_q  <= owner_inc;
        cnt_q  <= '0;
      end else if (stall) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if ((state_q == WAIT_DONE) && idle_i && !lock_q) ptr_q <= owner_inc;
    end
  end

  assign data_o     = data_q;
  assign tx_start_o = tx_start_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx and a serial-line receiver.
module tb_uart_tx_arbiter;

  localparam int unsigned BITCLK = uart_pkg::clks_per_bit(1000000, 100000);
  localparam int unsigned FRAME  = uart_pkg::clks_per_frame(1000000, 100000, 8);

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic [7:0]  dout;
  logic        tx_start;
  logic        idle;
  logic        busy;
  logic        timeout;

  int vectors;
  int miscompares;

  uart_tx_arbiter #(
    .N            (4),
    .WIDTH        (8),
    .LOCK_TIMEOUT (20)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .data_o      (dout),
    .tx_start_o  (tx_start),
    .idle_i      (idle),
    .busy_o      (busy),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  // Behavioural uart_tx: idle drops the cycle after start, frame of FRAME clocks, LSB first.
  logic [9:0] fr;
  int         fcnt;
  logic       txd;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle <= 1'b1;
      fcnt <= 0;
      fr   <= '1;
    end else if (idle) begin
      if (tx_start) begin
        idle <= 1'b0;
        fcnt <= 0;
        fr   <= {1'b1, dout, 1'b0};
      end
    end else if (fcnt == int'(FRAME) - 1) begin
      idle <= 1'b1;
      fcnt <= 0;
    end else begin
      fcnt <= fcnt + 1;
    end
  end
  assign txd = idle ? 1'b1 : fr[fcnt / int'(BITCLK)];

  // Serial receiver sampling mid-bit on the falling clock edge.
  logic       rx_act;
  int         rx_t;
  logic [7:0] rx_sh;
  int         rx_q[$];
  int         rx_err;
  always @(negedge clk) begin
    if (!rst_n) begin
      rx_act <= 1'b0;
    end else if (!rx_act) begin
      if (txd === 1'b0) begin
        rx_act <= 1'b1;
        rx_t   <= 0;
      end
    end else begin
      rx_t <= rx_t + 1;
      if ((rx_t + 1) % int'(BITCLK) == 5) begin
        if ((rx_t + 1) / int'(BITCLK) == 0) begin
          if (txd !== 1'b0) rx_err <= rx_err + 1;
        end else if ((rx_t + 1) / int'(BITCLK) <= 8) begin
          rx_sh[(rx_t + 1) / int'(BITCLK) - 1] <= txd;
        end else begin
          if (txd !== 1'b1) rx_err <= rx_err + 1;
          rx_q.push_back(int'(rx_sh));
          rx_act <= 1'b0;
        end
      end
    end
  end

  // Continuous protocol monitors: no start while uart busy, data held, ready one-hot and granted.
  int         overlap_err, hold_err, ready_err;
  logic       busy_prev;
  logic [7:0] data_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev <= 1'b0;
    end else begin
      if (tx_start && !idle) overlap_err <= overlap_err + 1;
      if (busy && busy_prev && dout !== data_prev) hold_err <= hold_err + 1;
      if ($countones(req_ready) > 1 || (req_ready != 4'b0 && req_ready != grant))
        ready_err <= ready_err + 1;
      busy_prev <= busy;
      data_prev <= dout;
    end
  end

  logic [8:0] lane_q[4][$];
  int         log_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_lanes();
    for (int k = 0; k < 4; k++) begin
      if (lane_q[k].size() > 0) begin
        req_valid[k]         = 1'b1;
        req_data[k*8 +: 8]   = lane_q[k][0][7:0];
        req_last[k]          = lane_q[k][0][8];
      end else begin
        req_valid[k] = 1'b0;
        req_last[k]  = 1'b0;
      end
    end
    #1;
  endtask

  // Serve every lane queue through the handshake until all drained and the UART is quiet.
  task automatic drive(input int budget);
    logic [3:0] acc;
    bit         done;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      acc = req_ready;
      for (int k = 0; k < 4; k++)
        if (acc[k]) log_q.push_back(k * 256 + int'(req_data[k*8 +: 8]));
      tick();
      for (int k = 0; k < 4; k++)
        if (acc[k]) void'(lane_q[k].pop_front());
      load_lanes();
      done = (lane_q[0].size() == 0) && (lane_q[1].size() == 0) && (lane_q[2].size() == 0) &&
             (lane_q[3].size() == 0) && !busy && !tx_start;
    end
    chk("drive_drained", 32'(done), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while (busy && c < budget) begin
      tick();
      c++;
    end
    chk("wait_idle_bound", 32'(busy), 32'd0);
  endtask

  task automatic expect_log(input string tag, input int exp);
    chk(tag, (log_q.size() > 0) ? 32'(log_q.pop_front()) : 32'hDEAD, 32'(exp));
  endtask

  task automatic expect_rx(input string tag, input int exp);
    chk(tag, (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'hDEAD, 32'(exp));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"},    32'(grant),     32'd0);
    chk({tag, "_ready"},    32'(req_ready), 32'd0);
    chk({tag, "_data"},     32'(dout),      32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start),  32'd0);
    chk({tag, "_busy"},     32'(busy),      32'd0);
    chk({tag, "_timeout"},  32'(timeout),   32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, leak, hold_bad, ready_bad;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single byte 0xA5 on lane 0.
    lane_q[0].push_back({1'b1, 8'hA5});
    load_lanes();
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_grant", 32'(grant), 32'h1);
    tick();
    void'(lane_q[0].pop_front());
    load_lanes();
    chk("single_start", 32'(tx_start), 32'd1);
    chk("single_data", 32'(dout), 32'hA5);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_ready_low", 32'(req_ready), 32'd0);
    tick();
    chk("single_start_pulse", 32'(tx_start), 32'd0);
    wait_idle(300);
    expect_rx("single_rx", 'hA5);
    // Pointer now 1: with lanes 0,2,3 valid, lane 2 must win.
    req_valid = 4'b1101;
    #1;
    chk("ptr_after_single", 32'(grant), 32'b0100);
    rst_n = 1'b0;
    #1;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Round robin from ptr 0.
    for (int k = 0; k < 4; k++) lane_q[k].push_back({1'b1, 8'(8'h10 + k)});
    load_lanes();
    drive(700);
    for (int k = 0; k < 4; k++) expect_log("rr0_order", k * 256 + 'h10 + k);
    for (int k = 0; k < 4; k++) expect_rx("rr0_rx", 'h10 + k);

    // Move ptr to 2, then round robin again.
    lane_q[1].push_back({1'b1, 8'h21});
    load_lanes();
    drive(300);
    expect_log("rr_setup", 'h121);
    expect_rx("rr_setup_rx", 'h21);
    for (int k = 0; k < 4; k++) lane_q[k].push_back({1'b1, 8'(8'h30 + k)});
    load_lanes();
    drive(700);
    expect_log("rr2_order_a", 'h232);
    expect_log("rr2_order_b", 'h333);
    expect_log("rr2_order_c", 'h030);
    expect_log("rr2_order_d", 'h131);
    expect_rx("rr2_rx_a", 'h32);
    expect_rx("rr2_rx_b", 'h33);
    expect_rx("rr2_rx_c", 'h30);
    expect_rx("rr2_rx_d", 'h31);

    // Packet lock: ptr -> 1, then lane 1 sends 3 bytes while lane 0 waits.
    lane_q[0].push_back({1'b1, 8'h40});
    load_lanes();
    drive(300);
    expect_log("lock_setup", 'h040);
    expect_rx("lock_setup_rx", 'h40);
    lane_q[1].push_back({1'b0, 8'h01});
    lane_q[1].push_back({1'b0, 8'h02});
    lane_q[1].push_back({1'b1, 8'h03});
    lane_q[0].push_back({1'b1, 8'h55});
    load_lanes();
    drive(900);
    expect_log("lock_b1", 'h101);
    expect_log("lock_b2", 'h102);
    expect_log("lock_b3", 'h103);
    expect_log("lock_then_lane0", 'h055);
    expect_rx("lock_rx1", 'h01);
    expect_rx("lock_rx2", 'h02);
    expect_rx("lock_rx3", 'h03);
    expect_rx("lock_rx4", 'h55);

    // Lock timeout: ptr 1, lane 2 locks with last=0 then goes quiet; lane 3 waits.
    lane_q[2].push_back({1'b0, 8'h66});
    lane_q[3].push_back({1'b1, 8'h77});
    load_lanes();
    chk("tmo_first_ready", 32'(req_ready), 32'b0100);
    tick();
    void'(lane_q[2].pop_front());
    load_lanes();
    chk("tmo_first_start", 32'(tx_start), 32'd1);
    wait_idle(300);
    n    = 0;
    leak = 0;
    while (!timeout && n < 100) begin
      if (grant != 4'b0 || req_ready != 4'b0) leak++;
      tick();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd20);
    chk("tmo_locked_out", 32'(leak), 32'd0);
    chk("tmo_pulse", 32'(timeout), 32'd1);
    chk("tmo_grant3", 32'(grant), 32'b1000);
    chk("tmo_ready3", 32'(req_ready), 32'b1000);
    tick();
    void'(lane_q[3].pop_front());
    load_lanes();
    chk("tmo_pulse_end", 32'(timeout), 32'd0);
    chk("tmo_lane3_data", 32'(dout), 32'h77);
    chk("tmo_lane3_start", 32'(tx_start), 32'd1);
    wait_idle(300);
    expect_rx("tmo_rx_a", 'h66);
    expect_rx("tmo_rx_b", 'h77);

    // Data hold: lane data changes and lane 1 requests while the frame is in flight.
    lane_q[0].push_back({1'b1, 8'h3C});
    load_lanes();
    tick();
    void'(lane_q[0].pop_front());
    lane_q[1].push_back({1'b1, 8'h78});
    load_lanes();
    req_data[7:0] = 8'hC3;
    #1;
    hold_bad  = 0;
    ready_bad = 0;
    n         = 0;
    while (busy && n < 300) begin
      if (dout !== 8'h3C) hold_bad++;
      if (req_ready != 4'b0) ready_bad++;
      tick();
      n++;
    end
    chk("hold_data", 32'(hold_bad), 32'd0);
    chk("hold_no_ready", 32'(ready_bad), 32'd0);
    chk("hold_late_ready", 32'(req_ready), 32'b0010);
    drive(300);
    expect_log("hold_next", 'h178);
    expect_rx("hold_rx_a", 'h3C);
    expect_rx("hold_rx_b", 'h78);

    // Reset during the data bits of a locked frame.
    lane_q[2].push_back({1'b0, 8'h96});
    load_lanes();
    tick();
    void'(lane_q[2].pop_front());
    load_lanes();
    chk("rst_mid_start", 32'(tx_start), 32'd1);
    repeat (40) tick();
    chk("rst_mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    lane_q[1].push_back({1'b1, 8'h5A});
    load_lanes();
    chk("rst_after_grant", 32'(grant), 32'b0010);
    drive(300);
    expect_log("rst_after_log", 'h15A);
    expect_rx("rst_after_rx", 'h5A);

    chk("mon_overlap", 32'(overlap_err), 32'd0);
    chk("mon_hold", 32'(hold_err), 32'd0);
    chk("mon_ready", 32'(ready_err), 32'd0);
    chk("mon_rx_framing", 32'(rx_err), 32'd0);
    chk("rx_leftover", 32'(rx_q.size()), 32'd0);
    chk("log_leftover", 32'(log_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
